// File: rtl/btn_multi_rpt.sv
// Multi-channel debouncer for active-low push buttons: shared sample tick,
// per-channel press / long-press / auto-repeat / release pulses and a debounced level.
module btn_multi_rpt #(
  parameter int CH           = 4,
  parameter int TICK_DIV     = 1250000,
  parameter int HOLD_TICKS   = 20,
  parameter int REPEAT_TICKS = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [CH-1:0] nBIN,
  input  logic [CH-1:0] REP_EN,
  output logic [CH-1:0] BOUT,
  output logic [CH-1:0] BLONG,
  output logic [CH-1:0] BREL,
  output logic [CH-1:0] BLVL
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

  logic [CW-1:0] cnt;
  logic          tick;
  logic [CH-1:0] ff1;
  logic [CH-1:0] ff2;

  assign tick = (cnt == CNT_LAST);

  // Samplers reset to "released" so a button held through reset shows up as a fresh press.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= '0;
      ff1 <= '1;
      ff2 <= '1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        ff2 <= ff1;
        ff1 <= nBIN;
      end
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    state_t        state;
    logic [HW-1:0] hcnt;
    logic [RW-1:0] rcnt;
    logic          long_done;
    logic          bout;
    logic          blong;
    logic          brel;
    logic          blvl;
    logic          press;
    logic          rel;
    logic          held;

    assign press = ff2[gi] & ~ff1[gi];
    assign rel   = ~ff2[gi] & ff1[gi];
    assign held  = ~ff1[gi];

    always_ff @(posedge CLK) begin
      if (!nRST) begin
        state     <= IDLE;
        hcnt      <= '0;
        rcnt      <= '0;
        long_done <= 1'b0;
        bout      <= 1'b0;
        blong     <= 1'b0;
        brel      <= 1'b0;
        blvl      <= 1'b0;
      end else begin
        bout  <= 1'b0;
        blong <= 1'b0;
        brel  <= 1'b0;
        if (tick) begin
          case (state)
            IDLE: begin
              if (press) begin
                state     <= HELD;
                hcnt      <= '0;
                long_done <= 1'b0;
                bout      <= 1'b1;
                blvl      <= 1'b1;
              end
            end
            HELD: begin
              if (rel) begin
                state <= IDLE;
                brel  <= 1'b1;
                blvl  <= 1'b0;
              end else if (held) begin
                // hcnt stays at the limit; long_done keeps BLONG to one pulse per hold.
                if (hcnt == HCNT_LAST) begin
                  if (!long_done) begin
                    blong     <= 1'b1;
                    long_done <= 1'b1;
                  end
                  if (REP_EN[gi]) begin
                    state <= REPEAT;
                    rcnt  <= '0;
                    bout  <= 1'b1;
                  end
                end else begin
                  hcnt <= hcnt + 1'b1;
                end
              end
            end
            REPEAT: begin
              if (rel) begin
                state <= IDLE;
                brel  <= 1'b1;
                blvl  <= 1'b0;
              end else if (held) begin
                if (rcnt == RCNT_LAST) begin
                  rcnt <= '0;
                  bout <= REP_EN[gi];
                end else begin
                  rcnt <= rcnt + 1'b1;
                end
              end
            end
            default: begin
              state <= IDLE;
              blvl  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign BOUT[gi]  = bout;
    assign BLONG[gi] = blong;
    assign BREL[gi]  = brel;
    assign BLVL[gi]  = blvl;
  end

endmodule

// File: tb/tb_btn_multi_rpt.sv
// Bench for btn_multi_rpt: directed scenarios plus random button activity,
// checked every cycle against a tick-level behavioural model.
module tb_btn_multi_rpt;

  localparam int CH = 2;
  localparam int TD = 4;
  localparam int HT = 3;
  localparam int RT = 2;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [CH-1:0] nbin = '1;
  logic [CH-1:0] rep_en = '0;
  logic [CH-1:0] bout, blong, brel, blvl;

  btn_multi_rpt #(.CH(CH), .TICK_DIV(TD), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)) dut (
    .CLK(clk), .nRST(nrst), .nBIN(nbin), .REP_EN(rep_en),
    .BOUT(bout), .BLONG(blong), .BREL(brel), .BLVL(blvl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: samples, press level, ticks held since the press, tick count at repeat entry.
  int            phase = 0;
  int            tick_no = 0;
  logic [CH-1:0] s1 = '1, s2 = '1, m_lvl = '0;
  logic [CH-1:0] e_bout = '0, e_blong = '0, e_brel = '0;
  int            age [CH];
  int            entry [CH];
  logic [63:0]   bout_at [CH];
  logic [63:0]   blong_at [CH];
  logic [63:0]   brel_at [CH];

  task automatic step();
    if (!nrst) begin
      phase = 0; s1 = '1; s2 = '1; m_lvl = '0;
      e_bout = '0; e_blong = '0; e_brel = '0;
      for (int c = 0; c < CH; c++) begin age[c] = 0; entry[c] = -1; end
    end else begin
      e_bout = '0; e_blong = '0; e_brel = '0;
      if (phase == TD - 1) begin
        phase = 0;
        tick_no++;
        for (int c = 0; c < CH; c++) begin
          if (!m_lvl[c]) begin
            if (s2[c] && !s1[c]) begin
              m_lvl[c] = 1'b1; age[c] = 0; entry[c] = -1; e_bout[c] = 1'b1;
            end
          end else if (!s2[c] && s1[c]) begin
            m_lvl[c] = 1'b0; e_brel[c] = 1'b1;
          end else if (!s1[c]) begin
            age[c]++;
            if (age[c] == HT) e_blong[c] = 1'b1;
            if (rep_en[c]) begin
              if (entry[c] < 0) begin
                if (age[c] >= HT) begin entry[c] = age[c]; e_bout[c] = 1'b1; end
              end else if ((age[c] - entry[c]) % RT == 0) begin
                e_bout[c] = 1'b1;
              end
            end
          end
        end
        s2 = s1;
        s1 = nbin;
      end else begin
        phase++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tick_no < 64) begin
      for (int c = 0; c < CH; c++) begin
        if (bout[c])  bout_at[c][tick_no]  = 1'b1;
        if (blong[c]) blong_at[c][tick_no] = 1'b1;
        if (brel[c])  brel_at[c][tick_no]  = 1'b1;
      end
    end
  endtask

  task automatic clear_rec();
    tick_no = 0;
    for (int c = 0; c < CH; c++) begin
      bout_at[c] = '0; blong_at[c] = '0; brel_at[c] = '0;
    end
  endtask

  task automatic align();
    step();
    while (phase != 0) step();
  endtask

  task automatic test_reset();
    nrst = 1'b0; nbin = 2'b00; rep_en = 2'b00;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bout, blong, brel, blvl} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=00", cyc, {bout, blong, brel, blvl});
      end
    end
    nrst = 1'b1;
    clear_rec();
    while (tick_no < 6) begin
      step();
      checks++;
      if ({bout, blong, brel, blvl} !== {e_bout, e_blong, e_brel, m_lvl}) begin
        errors++;
        $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, {bout, blong, brel, blvl}, {e_bout, e_blong, e_brel, m_lvl});
      end
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (bout_at[c] !== 64'h4 || brel_at[c] !== 64'h0) begin
        errors++;
        $display("FAIL reset_press ch%0d bout_ticks=%h brel_ticks=%h want bout=4 brel=0", c, bout_at[c], brel_at[c]);
      end
    end
    nbin = 2'b11;
    while (tick_no < 10) step();
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_short_press();
    align(); clear_rec();
    nbin[0] = 1'b0;
    while (tick_no < 6) begin
      if (tick_no == 2) nbin[0] = 1'b1;
      step();
      checks++;
      if ({bout, blong, brel, blvl} !== {e_bout, e_blong, e_brel, m_lvl}) begin
        errors++;
        $display("FAIL short_model cyc=%0d got=%h want=%h", cyc, {bout, blong, brel, blvl}, {e_bout, e_blong, e_brel, m_lvl});
      end
    end
    checks++;
    if (bout_at[0] !== 64'h4 || brel_at[0] !== 64'h10 || blong_at[0] !== 64'h0) begin
      errors++;
      $display("FAIL short_ch0 bout=%h brel=%h blong=%h want 4/10/0", bout_at[0], brel_at[0], blong_at[0]);
    end
    checks++;
    if ((bout_at[1] | brel_at[1] | blong_at[1]) !== 64'h0) begin
      errors++;
      $display("FAIL short_ch1_silent got=%h want=0", bout_at[1] | brel_at[1] | blong_at[1]);
    end
    $display("test_short_press done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_hold(input logic [CH-1:0] en, input int ch, input logic [63:0] want_bout, input bit drop);
    rep_en = en;
    align(); clear_rec();
    nbin[ch] = 1'b0;
    while (tick_no < 14) begin
      if (tick_no == 10) nbin[ch] = 1'b1;
      if (drop && tick_no == 5) rep_en[ch] = 1'b0;
      if (drop && tick_no == 7) rep_en[ch] = 1'b1;
      step();
      checks++;
      if ({bout, blong, brel, blvl} !== {e_bout, e_blong, e_brel, m_lvl}) begin
        errors++;
        $display("FAIL hold_model ch%0d cyc=%0d got=%h want=%h", ch, cyc, {bout, blong, brel, blvl}, {e_bout, e_blong, e_brel, m_lvl});
      end
    end
    checks++;
    if (bout_at[ch] !== want_bout) begin
      errors++;
      $display("FAIL hold_bout ch%0d got=%h want=%h", ch, bout_at[ch], want_bout);
    end
    checks++;
    if (blong_at[ch] !== 64'h20 || brel_at[ch] !== 64'h1000) begin
      errors++;
      $display("FAIL hold_long_rel ch%0d blong=%h brel=%h want 20/1000", ch, blong_at[ch], brel_at[ch]);
    end
    rep_en = '0;
    $display("test_hold ch%0d rep_en=%b drop=%0d done: checks=%0d errors=%0d", ch, en, drop, checks, errors);
  endtask

  task automatic test_reset_mid_repeat();
    rep_en = 2'b11;
    align(); clear_rec();
    nbin[1] = 1'b0;
    while (tick_no < 7) step();
    checks++;
    if (blvl[1] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre_level got=%b want=1", blvl[1]);
    end
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    checks++;
    if ({bout, blong, brel, blvl} !== 8'h00) begin
      errors++;
      $display("FAIL midrst_outputs got=%h want=00", {bout, blong, brel, blvl});
    end
    clear_rec();
    while (tick_no < 4) begin
      step();
      checks++;
      if ({bout, blong, brel, blvl} !== {e_bout, e_blong, e_brel, m_lvl}) begin
        errors++;
        $display("FAIL midrst_model cyc=%0d got=%h want=%h", cyc, {bout, blong, brel, blvl}, {e_bout, e_blong, e_brel, m_lvl});
      end
    end
    checks++;
    if (bout_at[1] !== 64'h4 || brel_at[1] !== 64'h0) begin
      errors++;
      $display("FAIL midrst_repress bout=%h brel=%h want 4/0", bout_at[1], brel_at[1]);
    end
    nbin = 2'b11; rep_en = '0;
    while (tick_no < 8) step();
    $display("test_reset_mid_repeat done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    int idx;
    for (int i = 0; i < 4000; i++) begin
      idx = int'($urandom_range(CH - 1, 0));
      if ($urandom_range(11, 0) == 0) nbin[idx] = ~nbin[idx];
      idx = int'($urandom_range(CH - 1, 0));
      if ($urandom_range(39, 0) == 0) rep_en[idx] = ~rep_en[idx];
      nrst = ($urandom_range(799, 0) != 0);
      step();
      checks++;
      if ({bout, blong, brel, blvl} !== {e_bout, e_blong, e_brel, m_lvl}) begin
        errors++;
        $display("FAIL random_model cyc=%0d nbin=%b rep_en=%b got=%h want=%h", cyc, nbin, rep_en, {bout, blong, brel, blvl}, {e_bout, e_blong, e_brel, m_lvl});
      end
    end
    nrst = 1'b1;
    $display("test_random done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    for (int c = 0; c < CH; c++) begin age[c] = 0; entry[c] = -1; end
    test_reset();
    test_short_press();
    test_hold(2'b00, 0, 64'h4, 1'b0);
    test_hold(2'b11, 1, 64'hAA4, 1'b0);
    test_hold(2'b11, 1, 64'hA24, 1'b1);
    test_reset_mid_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
